// File: rtl/fetch_buffer.sv
// Fetch-to-decode instruction queue with valid/ready handshake, flush and back-pressure.
// Optional zero-latency bypass when empty: define FETCH_BUF_BYPASS_EN.
module fetch_buffer #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WORD_W-1:0]          in_instr,
  input  logic [WORD_W-1:0]          in_pc,
  input  logic                       in_branch_pred,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WORD_W-1:0]          out_instr,
  output logic [WORD_W-1:0]          out_pc,
  output logic                       out_branch_pred,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WORD_W-1:0] instr_mem [DEPTH];
  logic [WORD_W-1:0] pc_mem    [DEPTH];
  logic [DEPTH-1:0]  pred_mem;

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  cnt;

  logic empty;
  logic full;
  logic push;
  logic pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_W'(DEPTH));
  assign in_ready = ~full;
  assign count    = cnt;

`ifdef FETCH_BUF_BYPASS_EN
  logic bypass;

  // An empty buffer forwards fetch straight to decode; the entry is only
  // stored if decode does not take it this cycle.
  assign bypass    = empty & in_valid & ~flush;
  assign out_valid = ~empty | bypass;
  assign pop       = ~empty & out_ready & ~flush;
  assign push      = in_valid & in_ready & ~flush & ~(bypass & out_ready);

  always_comb begin
    out_instr       = '0;
    out_pc          = '0;
    out_branch_pred = 1'b0;
    if (!empty) begin
      out_instr       = instr_mem[head];
      out_pc          = pc_mem[head];
      out_branch_pred = pred_mem[head];
    end else if (bypass) begin
      out_instr       = in_instr;
      out_pc          = in_pc;
      out_branch_pred = in_branch_pred;
    end
  end
`else
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready & ~flush;
  assign push      = in_valid & in_ready & ~flush;

  always_comb begin
    out_instr       = '0;
    out_pc          = '0;
    out_branch_pred = 1'b0;
    if (!empty) begin
      out_instr       = instr_mem[head];
      out_pc          = pc_mem[head];
      out_branch_pred = pred_mem[head];
    end
  end
`endif

  // Storage is data only and is never reset; empty-state outputs are masked above.
  always_ff @(posedge CLK) begin
    if (push) begin
      instr_mem[tail] <= in_instr;
      pc_mem[tail]    <= in_pc;
      pred_mem[tail]  <= in_branch_pred;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed table-driven bench for fetch_buffer plus hand sequences for reset and bypass.
module tb_fetch_buffer;

  logic        CLK;
  logic        RST;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_branch_pred;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_branch_pred;
  logic        out_ready;
  logic [2:0]  count;

  fetch_buffer #(.DEPTH(4), .WORD_W(32)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_branch_pred(in_branch_pred), .in_ready(in_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_branch_pred(out_branch_pred), .out_ready(out_ready), .count(count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic [2:0]  cnt;
    logic        ovld;
    logic [31:0] opc;
    logic        irdy;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_err;

  // Instruction word is tied to the pc so that head identity can be checked twice.
  function automatic logic [31:0] f_instr(input logic [31:0] pc);
    return 32'hAAAA0000 + ((pc - 32'h100) >> 2) + 32'd1;
  endfunction

  function automatic logic f_bp(input logic [31:0] pc);
    return (pc == 32'h104);
  endfunction

  function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] pc,
                              input logic ordy, input logic [2:0] cnt, input logic ovld,
                              input logic [31:0] opc, input logic irdy);
    vec_t v;
    v.fl = fl; v.iv = iv; v.pc = pc; v.ordy = ordy;
    v.cnt = cnt; v.ovld = ovld; v.opc = opc; v.irdy = irdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0; in_branch_pred = 1'b0;
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] pc, input logic ordy);
    flush = fl; in_valid = iv; in_pc = pc; in_instr = f_instr(pc);
    in_branch_pred = f_bp(pc); out_ready = ordy;
  endtask

  // Apply one cycle of stimulus, then return inputs to idle and sample mid-cycle.
  task automatic step(input logic fl, input logic iv, input logic [31:0] pc, input logic ordy);
    drive(fl, iv, pc, ordy);
    @(posedge CLK);
    #1 idle();
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [2:0] cnt, input logic ovld,
                          input logic [31:0] opc, input logic irdy);
    chk({tag, "_count"}, 32'(count), 32'(cnt));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(ovld));
    chk({tag, "_out_pc"}, out_pc, opc);
    chk({tag, "_out_instr"}, out_instr, ovld ? f_instr(opc) : 32'h0);
    chk({tag, "_out_bp"}, 32'(out_branch_pred), 32'(ovld & f_bp(opc)));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(irdy));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // In-order stream, then drain
    vecs.push_back(mk(0, 1, 32'h100, 0, 1, 1, 32'h100, 1));
    vecs.push_back(mk(0, 1, 32'h104, 0, 2, 1, 32'h100, 1));
    vecs.push_back(mk(0, 1, 32'h108, 0, 3, 1, 32'h100, 1));
    vecs.push_back(mk(0, 0, 32'h0,   1, 2, 1, 32'h104, 1));
    vecs.push_back(mk(0, 0, 32'h0,   1, 1, 1, 32'h108, 1));
    vecs.push_back(mk(0, 0, 32'h0,   1, 0, 0, 32'h0,   1));
    // Fill to full, 5th push ignored, pop-while-full blocks the push
    vecs.push_back(mk(0, 1, 32'h10C, 0, 1, 1, 32'h10C, 1));
    vecs.push_back(mk(0, 1, 32'h110, 0, 2, 1, 32'h10C, 1));
    vecs.push_back(mk(0, 1, 32'h114, 0, 3, 1, 32'h10C, 1));
    vecs.push_back(mk(0, 1, 32'h118, 0, 4, 1, 32'h10C, 0));
    vecs.push_back(mk(0, 1, 32'h11C, 0, 4, 1, 32'h10C, 0));
    vecs.push_back(mk(0, 1, 32'h11C, 1, 3, 1, 32'h110, 1));
    vecs.push_back(mk(0, 1, 32'h11C, 0, 4, 1, 32'h110, 0));
    // Drain to two, then ten cycles of simultaneous push/pop across the wrap
    vecs.push_back(mk(0, 0, 32'h0,   1, 3, 1, 32'h114, 1));
    vecs.push_back(mk(0, 0, 32'h0,   1, 2, 1, 32'h118, 1));
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk(0, 1, 32'h120 + 32'(4 * k), 1, 2, 1, 32'h11C + 32'(4 * k), 1));
    // Flush with push and pop presented, then restart
    vecs.push_back(mk(0, 1, 32'h148, 0, 3, 1, 32'h140, 1));
    vecs.push_back(mk(1, 1, 32'h14C, 1, 0, 0, 32'h0,   1));
    vecs.push_back(mk(0, 1, 32'h150, 0, 1, 1, 32'h150, 1));
    vecs.push_back(mk(0, 0, 32'h0,   1, 0, 0, 32'h0,   1));

    idle();
    RST = 1'b1;
    #2;
    chk_head("reset", 3'd0, 1'b0, 32'h0, 1'b1);
    #1 RST = 1'b0;
    @(posedge CLK);
    #2;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
      chk_head($sformatf("v%0d", i), vecs[i].cnt, vecs[i].ovld, vecs[i].opc, vecs[i].irdy);
    end

    // Asynchronous reset mid-cycle with three entries held
    step(0, 1, 32'h200, 0);
    step(0, 1, 32'h204, 0);
    step(0, 1, 32'h208, 0);
    chk("pre_rst_count", 32'(count), 32'd3);
    #2 RST = 1'b1;
    #1;
    chk_head("async_rst", 3'd0, 1'b0, 32'h0, 1'b1);
    #1 RST = 1'b0;
    @(posedge CLK);
    #2;
    step(0, 1, 32'h300, 0);
    chk_head("post_rst", 3'd1, 1'b1, 32'h300, 1'b1);
    step(0, 0, 32'h0, 1);
    chk_head("post_rst_drain", 3'd0, 1'b0, 32'h0, 1'b1);

    // Flush suppresses any forwarding from an empty buffer
    drive(1, 1, 32'h200, 1);
    #1;
    chk("flush_empty_out_valid", 32'(out_valid), 32'd0);
    @(posedge CLK);
    #1 idle();
    #1;
    chk("flush_empty_count", 32'(count), 32'd0);

    // Empty buffer, fetch and decode both ready
    drive(0, 1, 32'h200, 1);
    #1;
`ifdef FETCH_BUF_BYPASS_EN
    chk("bypass_out_valid", 32'(out_valid), 32'd1);
    chk("bypass_out_pc", out_pc, 32'h200);
    chk("bypass_out_instr", out_instr, f_instr(32'h200));
    @(posedge CLK);
    #1 idle();
    #1;
    chk_head("bypass_after", 3'd0, 1'b0, 32'h0, 1'b1);
`else
    chk("nobypass_out_valid", 32'(out_valid), 32'd0);
    chk("nobypass_out_pc", out_pc, 32'h0);
    @(posedge CLK);
    #1 idle();
    #1;
    chk_head("nobypass_after", 3'd1, 1'b1, 32'h200, 1'b1);
    step(0, 0, 32'h0, 1);
    chk_head("nobypass_drain", 3'd0, 1'b0, 32'h0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction queue between the fetch stage and decode.
- Captures each fetched {instr, pc, branch_pred} on ihit and presents entries in order to decode through a valid/ready handshake.
- Back-pressures fetch (in_ready drives fetch freeze) and drops all contents on a misprediction flush.
- Decouples fetch hit timing from decode stalls.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- WORD_W, 32, width of instr and pc (matches word_t).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- flush  input  1  misprediction flush from execute; clears queue.
- in_valid  input  1  fetch has a valid instruction this cycle (ihit & ~flush at fetch).
- in_instr  input  WORD_W  fetched instruction.
- in_pc  input  WORD_W  pc of fetched instruction.
- in_branch_pred  input  1  fetch's taken prediction for this instruction.
- in_ready  output  1  buffer can accept; fetch freeze = ~in_ready.
- out_valid  output  1  head entry valid for decode.
- out_instr  output  WORD_W  head instruction.
- out_pc  output  WORD_W  head pc.
- out_branch_pred  output  1  head prediction bit.
- out_ready  input  1  decode accepts head this cycle.
- count  output  log2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH entries of {instr, pc, branch_pred}; head/tail pointers of log2(DEPTH) bits wrap modulo DEPTH; separate count register, 0..DEPTH.
- Reset (async, RST=1): head=tail=count=0; out_valid=0, in_ready=1; out_instr/out_pc=0, out_branch_pred=0. Entry storage contents need not be reset, but outputs must read 0 while empty.
- Reset mid-operation: all state clears immediately, without waiting for a clock edge. The first accepted push after RST falls becomes the head.
- push = in_valid & in_ready & ~flush; writes the tail entry and increments tail at the edge.
- pop = out_valid & out_ready & ~flush; increments head at the edge.
- in_ready = (count != DEPTH), a combinational function of registered count.
  - No push-when-full even if popping in the same cycle, so there is no combinational path from out_ready to in_ready.
- out_valid = (count != 0). out_* are driven from the head entry, or zeros when empty.
- Latency: an entry pushed at edge N is visible on out_* after edge N (1-cycle latency); see the optional feature.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
  - neither: hold.
- Flush:
  - Highest priority. At the edge, head=tail=count=0.
  - Any push or pop presented in the flush cycle is discarded.
  - out_valid=0 in the cycle after flush.
  - in_ready is unaffected during the flush cycle (it still reflects the old count).
- Full: in_ready=0; fetch holds its pc/instr, and in_valid may remain high without effect.
- Empty: out_valid=0; out_ready is ignored.
- Wrap-around: pointers roll from DEPTH-1 to 0; FIFO order is preserved across the wrap.
- No internal FSM beyond the occupancy states EMPTY (count=0), PARTIAL, FULL (count=DEPTH), all derived from count.

Optional Feature:
- FETCH_BUF_BYPASS_EN.
- Defined:
  - When count=0 and in_valid=1, out_valid=1 combinationally and out_* are driven directly from in_*.
  - If out_ready=1 in that cycle, the instruction passes to decode with 0-cycle latency and is not written. Count and pointers are unchanged.
  - If out_ready=0, the instruction is written normally (count becomes 1).
  - flush still suppresses the bypass: out_valid=0 whenever flush=1 and count=0.
- Undefined: strict 1-cycle latency; out_* are always sourced from storage.

Test Plan:
- Reset: assert RST mid-cycle with count=3 -> count=0, out_valid=0, in_ready=1 immediately, before the next edge.
- In-order stream: push pc 0x100/0x104/0x108 (instrs 0xAAAA0001..3) with out_ready=0, then hold out_ready=1 -> out_pc 0x100, 0x104, 0x108 on consecutive cycles; count 3->0.
- Full/back-pressure: push 4 entries with out_ready=0 -> count=4, in_ready=0; a 5th in_valid is ignored. One pop -> in_ready=1 next cycle, and the 5th entry is accepted afterward.
- Simultaneous push/pop at count=2 over 10 cycles -> count stays 2; pointers wrap past DEPTH-1; out_pc sequence is strictly increasing by 4.
- Flush: count=3 with in_valid=1 and out_ready=1 in the flush cycle -> next cycle count=0, out_valid=0, and neither that push nor that pop takes effect.
- Bypass (FETCH_BUF_BYPASS_EN): empty buffer, in_valid=1, out_ready=1, in_pc=0x200 -> same cycle out_valid=1, out_pc=0x200, count stays 0. Without the macro: out_valid rises one cycle later.
